gray_updown_nbits: RTL and testbench
====================================

# gray_updown_nbits

Parametrised up/down Gray-code counter with synchronous load, wrap or saturate mode, and a registered boundary pulse. It drives the 7-segment display path and serves as the general replacement for the fixed-direction N-bit Gray counter. It also feeds any consumer that needs single-bit-change sequencing, such as pointers or encoders. Both Gray and binary views of the count are registered and cycle-consistent.

## Interface
- `N`, default 4: counter width in bits; legal range 2..16.
- `WRAP`, default 1: 1 means wrap at sequence ends; 0 means saturate at sequence ends.
- `clk` input, 1 bit: clock, rising-edge.
- `reset` input, 1 bit: asynchronous, active-high; clock is `clk`.
- `enable` input, 1 bit: advance one step this cycle.
- `up` input, 1 bit: direction, 1 = increment sequence index, 0 = decrement; sampled every cycle.
- `load` input, 1 bit: synchronous load of `load_value`.
- `load_value` input, N bits: binary sequence index to load.
- `gray_out` output, N bits: current count, reflected-binary Gray code.
- `bin_out` output, N bits: binary sequence index of `gray_out`, same cycle.
- `bound` output, 1 bit: one-cycle pulse when an enabled step hits a sequence end (wrap, or saturation hold).

## Operation
- Sequence is standard reflected binary Gray: `gray = bin ^ (bin >> 1)`. Index 0 = all zeros; index 2^N-1 = MSB set, rest zero.
- Internal state is the N-bit Gray register plus a parity bit equal to XOR of the Gray bits.
- Next state is computed directly from Gray and parity, without a binary adder:
  - up with even parity: toggle bit 0.
  - up with odd parity: toggle the bit left of the lowest set bit.
  - down uses the inverse rule (odd: toggle bit 0; even: toggle the bit left of the lowest set bit).
  - Exception: when the lowest set bit is the MSB, the end-of-sequence rule below applies.
- `bin_out` is registered alongside the Gray register. Its next value is derived from the next Gray state by prefix-XOR, so no extra cycle is spent.
- Priority is reset > load > enable > hold.
- Load: `gray_out <= bin2gray(load_value)`, `bin_out <= load_value`, parity updated, `bound` = 0. `enable` and `up` are ignored in that cycle.
- enable = 0 and load = 0: all state holds; `bound` = 0.
- Sequence ends:
  - Up at index 2^N-1, WRAP = 1: go to index 0, `bound` = 1.
  - Up at index 2^N-1, WRAP = 0: hold, `bound` = 1.
  - Down at index 0 mirrors the up case: WRAP = 1 goes to index 2^N-1; WRAP = 0 holds. `bound` = 1 in both.
- Every non-load, non-reset transition changes exactly one bit of `gray_out`. This includes the wrap step.
- A direction change between consecutive enabled cycles is legal and takes effect immediately.

## Timing
- All outputs are registered; latency from input to output is 1 clock.
- Reset values: `gray_out` = 0, `bin_out` = 0, `bound` = 0, parity = 0.
- Reset asserted mid-count clears all state immediately (asynchronous). Counting resumes on the first rising edge after deassertion with `enable` = 1.
- `bound` is high for exactly the one cycle following the boundary step. Back-to-back saturation attempts give `bound` = 1 on every such cycle.
- load and enable in the same cycle: load wins; the step is discarded.

## Structure
- Package `gray_pkg` holds:
  - functions `bin2gray` and `gray2bin`, both parameterised by width;
  - a `lowest_set` priority function;
  - constant `GRAY_MAX_N` = 16.
- One sub-module, `gray_step`: combinational next-Gray and next-parity from (gray, parity, up, WRAP), plus an end-of-sequence flag. It is instantiated once.
- The top level holds the registers, the priority mux and the binary register.

## Test plan
- N=4, WRAP=1, up=1, enable high for 17 cycles from reset:
  - `gray_out` must read 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0.
  - `bound` = 1 only on the 8→0 step.
  - `bin_out` must read 0..15,0.
- N=4, WRAP=1, up=0 from reset: the first step gives `gray_out` = 8, `bin_out` = 15, `bound` = 1. The next step gives 9, `bin_out` = 14.
- N=4, WRAP=0: load 15 then hold enable, up=1 for 3 cycles. `gray_out` stays 8 and `bound` = 1 on each of the 3 cycles. Then up=0 steps to 9.
- load_value = 10 with enable = 1 and up = 1 in the same cycle: next `gray_out` = 15, `bin_out` = 10, `bound` = 0.
- Count up to index 6, then assert reset asynchronously between edges. Outputs must be 0 before the next edge. After release, the next enabled step gives 1.
- Random enable, up and load over 10k cycles for N = 2, 4, 8. Check on every cycle:
  - single-bit change on each non-load step;
  - `bin_out == gray2bin(gray_out)`;
  - parity consistent with the Gray bits.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the up/down Gray counter.
// Vectors are carried at GRAY_MAX_N bits; narrower counters zero-extend.
package gray_pkg;

    localparam int GRAY_MAX_N = 16;

    function automatic logic [GRAY_MAX_N-1:0] bin2gray(input logic [GRAY_MAX_N-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended upper bits do not disturb the result.
    function automatic logic [GRAY_MAX_N-1:0] gray2bin(input logic [GRAY_MAX_N-1:0] gray);
        logic [GRAY_MAX_N-1:0] bin;
        bin[GRAY_MAX_N-1] = gray[GRAY_MAX_N-1];
        for (int i = GRAY_MAX_N - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Index of the lowest set bit; 0 when the vector is all zeros.
    function automatic int lowest_set(input logic [GRAY_MAX_N-1:0] vec);
        int idx;
        idx = 0;
        for (int i = GRAY_MAX_N - 1; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/gray_step.sv
// Combinational next-state for a reflected-binary Gray counter, computed from
// the Gray bits and their parity with no binary adder.
module gray_step
    import gray_pkg::*;
#(
    parameter int N    = 4,
    parameter bit WRAP = 1'b1
) (
    input  logic [N-1:0] gray,
    input  logic         parity,
    input  logic         up,
    output logic [N-1:0] next_gray,
    output logic         next_parity,
    output logic         at_end
);

    localparam logic [N-1:0] MSB_ONLY = {1'b1, {(N-1){1'b0}}};

    int           sel;
    logic         do_toggle;
    logic [N-1:0] mask;

    always_comb begin
        sel       = 0;
        do_toggle = 1'b1;
        mask      = '0;
        // Top of sequence is the lone MSB (odd parity); bottom is all zeros.
        at_end    = up ? (parity && gray == MSB_ONLY) : (!parity && gray == '0);

        if (at_end) begin
            sel       = N - 1;
            do_toggle = WRAP;
        end else if (up != parity) begin
            sel = 0;
        end else begin
            sel = lowest_set(GRAY_MAX_N'(gray)) + 1;
        end

        for (int i = 0; i < N; i++) begin
            mask[i] = do_toggle && (i == sel);
        end

        next_gray   = gray ^ mask;
        next_parity = parity ^ do_toggle;
    end

endmodule

// File: rtl/gray_updown_nbits.sv
// Up/down Gray counter with synchronous load, wrap/saturate ends, registered
// binary view and a one-cycle boundary pulse.
module gray_updown_nbits
    import gray_pkg::*;
#(
    parameter int N    = 4,
    parameter bit WRAP = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] load_value,
    output logic [N-1:0] gray_out,
    output logic [N-1:0] bin_out,
    output logic         bound
);

    if (N < 2 || N > GRAY_MAX_N) begin : g_bad_width
        $error("gray_updown_nbits: N must be within 2..16");
    end

    logic         parity;
    logic [N-1:0] step_gray;
    logic         step_parity;
    logic         step_end;
    logic [N-1:0] step_bin;
    logic [N-1:0] load_gray;

    gray_step #(
        .N    (N),
        .WRAP (WRAP)
    ) u_step (
        .gray        (gray_out),
        .parity      (parity),
        .up          (up),
        .next_gray   (step_gray),
        .next_parity (step_parity),
        .at_end      (step_end)
    );

    // Binary view follows the next Gray state in the same cycle.
    always_comb begin
        step_bin  = N'(gray2bin(GRAY_MAX_N'(step_gray)));
        load_gray = N'(bin2gray(GRAY_MAX_N'(load_value)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gray_out <= '0;
            bin_out  <= '0;
            parity   <= 1'b0;
            bound    <= 1'b0;
        end else if (load) begin
            gray_out <= load_gray;
            bin_out  <= load_value;
            parity   <= ^load_gray;
            bound    <= 1'b0;
        end else if (enable) begin
            gray_out <= step_gray;
            bin_out  <= step_bin;
            parity   <= step_parity;
            bound    <= step_end;
        end else begin
            bound    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_updown_nbits.sv
// Randomised and directed check of gray_updown_nbits against an index-based model.
module tb_gray_updown_nbits;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        up;
    logic        load;
    logic [15:0] lv;

    logic [3:0] g4, b4, g4s, b4s;
    logic [1:0] g2, b2;
    logic [7:0] g8, b8;
    logic       bd4, bd4s, bd2, bd8;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    gray_updown_nbits #(.N(4), .WRAP(1'b1)) u4 (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(lv[3:0]), .gray_out(g4), .bin_out(b4), .bound(bd4));
    gray_updown_nbits #(.N(4), .WRAP(1'b0)) u4s (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(lv[3:0]), .gray_out(g4s), .bin_out(b4s), .bound(bd4s));
    gray_updown_nbits #(.N(2), .WRAP(1'b1)) u2 (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(lv[1:0]), .gray_out(g2), .bin_out(b2), .bound(bd2));
    gray_updown_nbits #(.N(8), .WRAP(1'b0)) u8 (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(lv[7:0]), .gray_out(g8), .bin_out(b8), .bound(bd8));

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the counter is a sequence index; Gray is derived only for comparison.
    int m_idx[4];
    bit m_bnd[4];
    int NS[4]   = '{4, 4, 2, 8};
    bit WS[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit m_skip;
    bit m_load_last;

    function automatic int mstep(int idx, int n, bit w, bit en, bit u, bit ld, int v);
        int mx;
        mx = (1 << n) - 1;
        if (ld) return v & mx;
        if (!en) return idx;
        if (u) begin
            if (idx == mx) return (1 << 16) | (w ? 0 : mx);
            return idx + 1;
        end
        if (idx == 0) return (1 << 16) | (w ? mx : 0);
        return idx - 1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                m_idx[k] <= 0;
                m_bnd[k] <= 1'b0;
            end
            m_skip      <= 1'b1;
            m_load_last <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                m_idx[k] <= mstep(m_idx[k], NS[k], WS[k], enable, up, load, int'(lv)) & 16'hffff;
                m_bnd[k] <= ((mstep(m_idx[k], NS[k], WS[k], enable, up, load, int'(lv)) >> 16) & 1) != 0;
            end
            m_skip      <= 1'b0;
            m_load_last <= load;
        end
    end

    task automatic cmp(input string nm, input int k, input int g, input int b, input int bd);
        check({nm, "_gray"},  g,  m_idx[k] ^ (m_idx[k] >> 1));
        check({nm, "_bin"},   b,  m_idx[k]);
        check({nm, "_bound"}, bd, int'(m_bnd[k]));
    endtask

    logic [7:0] prev_g8 = '0;

    always @(negedge clk) begin
        cmp("u4",  0, int'(g4),  int'(b4),  int'(bd4));
        cmp("u4s", 1, int'(g4s), int'(b4s), int'(bd4s));
        cmp("u2",  2, int'(g2),  int'(b2),  int'(bd2));
        cmp("u8",  3, int'(g8),  int'(b8),  int'(bd8));
        if (!m_skip && !m_load_last)
            check("u8_onebit", int'($countones(g8 ^ prev_g8) <= 1), 1);
        prev_g8 = g8;
    end

    task automatic cyc(input bit en, input bit u, input bit ld, input int v);
        enable = en;
        up     = u;
        load   = ld;
        lv     = 16'(v);
        @(posedge clk);
        #1;
    endtask

    int tbl[16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        up     = 1'b0;
        load   = 1'b0;
        lv     = '0;
        #12;
        check("rst_gray",  int'(g4),  0);
        check("rst_bin",   int'(b4),  0);
        check("rst_bound", int'(bd4), 0);
        reset = 1'b0;

        // Full up cycle with wrap.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 0);
            check("up_gray",  int'(g4),  tbl[i]);
            check("up_bin",   int'(b4),  (i + 1) % 16);
            check("up_bound", int'(bd4), (i == 15) ? 1 : 0);
        end

        // Down from reset wraps to the top.
        reset = 1'b1; #1; reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 0);
        check("dn_gray",  int'(g4),  8);
        check("dn_bin",   int'(b4),  15);
        check("dn_bound", int'(bd4), 1);
        cyc(1'b1, 1'b0, 1'b0, 0);
        check("dn2_gray",  int'(g4),  9);
        check("dn2_bin",   int'(b4),  14);
        check("dn2_bound", int'(bd4), 0);

        // Saturation at the top.
        cyc(1'b0, 1'b0, 1'b1, 15);
        check("sat_load_gray", int'(g4s), 8);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 0);
            check("sat_gray",  int'(g4s),  8);
            check("sat_bound", int'(bd4s), 1);
        end
        cyc(1'b1, 1'b0, 1'b0, 0);
        check("sat_dn_gray",  int'(g4s),  9);
        check("sat_dn_bound", int'(bd4s), 0);

        // Load beats enable.
        cyc(1'b1, 1'b1, 1'b1, 10);
        check("ld_gray",  int'(g4),  15);
        check("ld_bin",   int'(b4),  10);
        check("ld_bound", int'(bd4), 0);

        // Asynchronous reset mid-count.
        reset = 1'b1; #1; reset = 1'b0;
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 0);
        check("mid_gray", int'(g4), 5);
        enable = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_gray", int'(g4), 0);
        check("async_bin",  int'(b4), 0);
        reset = 1'b0;
        #1;
        cyc(1'b1, 1'b1, 1'b0, 0);
        check("resume_gray", int'(g4), 1);

        // Random traffic, checked every cycle by the model.
        for (int i = 0; i < 10000; i++) begin
            cyc(($urandom % 4) != 0, $urandom % 2 == 1, ($urandom % 16) == 0, int'($urandom % 65536));
        end

        enable = 1'b0;
        load   = 1'b0;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
